// File: rtl/lib_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lib_mul_pkg
// Description : Shared constants and FSM state encoding for the multiplier
//               response serializer (product/word widths, state values).
// Revision    : 1.0 - initial release
// ============================================================================
package lib_mul_pkg;

  localparam int c_PROD_W = 64;
  localparam int c_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

  // Plain-vector views of the states for code that keeps state as logic [1:0]
  localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
  localparam logic [1:0] c_ST_FIRST  = ST_FIRST;
  localparam logic [1:0] c_ST_SECOND = ST_SECOND;

endpackage
`default_nettype wire

// File: rtl/lib_mul_rsp_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : lib_mul_rsp_serializer_if
// Description : Handshake bundle for the response serializer.
//               rsp_in/rsp_val/rsp_rdy : 64-bit product input (val/rdy)
//               out_data/out_val/out_rdy/out_last : 32-bit word output
//               slave  : serializer side (consumes products, emits words)
//               master : environment side (supplies products, takes words)
// Revision    : 1.0 - initial release
// ============================================================================
interface lib_mul_rsp_serializer_if;
  import lib_mul_pkg::*;

  logic [c_PROD_W-1:0] rsp_in;
  logic                rsp_val;
  logic                rsp_rdy;
  logic [c_WORD_W-1:0] out_data;
  logic                out_val;
  logic                out_rdy;
  logic                out_last;

  modport slave (
    input  rsp_in, rsp_val, out_rdy,
    output rsp_rdy, out_data, out_val, out_last
  );

  modport master (
    output rsp_in, rsp_val, out_rdy,
    input  rsp_rdy, out_data, out_val, out_last
  );

endinterface
`default_nettype wire

// File: rtl/lib_mul_rsp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : lib_mul_rsp_serializer
// Description : Splits each 64-bit multiplier product into two 32-bit
//               val/rdy beats (order set by LO_FIRST) and counts fully
//               emitted products.
//   clk      : clock, all state on rising edge
//   reset    : synchronous active-high reset
//   bus      : slave modport (rsp_* product input, out_* word output)
//   prod_cnt : number of completed products, wraps at 2**CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module lib_mul_rsp_serializer
  import lib_mul_pkg::*;
#(
  parameter bit LO_FIRST = 1'b1,
  parameter int CNT_W    = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  lib_mul_rsp_serializer_if.slave bus,
  output logic [CNT_W-1:0]        prod_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]          r_state;
  logic [c_PROD_W-1:0] r_hold;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_rsp_rdy;
  logic                w_out_val;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [c_WORD_W-1:0] w_lo;
  logic [c_WORD_W-1:0] w_hi;
  logic [c_WORD_W-1:0] w_out_data;

  // A new product is taken when idle, or while the second beat leaves so
  // back-to-back products stream with no bubble.
  assign w_rsp_rdy  = !reset && ((r_state == c_ST_IDLE) ||
                                 ((r_state == c_ST_SECOND) && bus.out_rdy));
  // Gated by reset so outputs are quiet for the whole reset cycle, not only
  // after the first edge.
  assign w_out_val  = !reset && (r_state != c_ST_IDLE);
  assign w_in_fire  = bus.rsp_val && w_rsp_rdy;
  assign w_out_fire = w_out_val && bus.out_rdy;

  assign w_lo = r_hold[c_WORD_W-1:0];
  assign w_hi = r_hold[c_PROD_W-1:c_WORD_W];

  always_comb begin
    w_out_data = '0;
    case (r_state)
      c_ST_FIRST:  w_out_data = LO_FIRST ? w_lo : w_hi;
      c_ST_SECOND: w_out_data = LO_FIRST ? w_hi : w_lo;
      default:     w_out_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_in_fire) begin
        r_hold <= bus.rsp_in;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (w_in_fire) r_state <= c_ST_FIRST;
        end
        c_ST_FIRST: begin
          if (w_out_fire) r_state <= c_ST_SECOND;
        end
        c_ST_SECOND: begin
          if (w_out_fire) begin
            r_cnt   <= r_cnt + c_CNT_ONE;
            r_state <= w_in_fire ? c_ST_FIRST : c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_rdy  = w_rsp_rdy;
  assign bus.out_val  = w_out_val;
  assign bus.out_data = w_out_data;
  assign bus.out_last = w_out_val && (r_state == c_ST_SECOND);
  assign prod_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lib_mul_rsp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lib_mul_rsp_serializer
// Description : Scoreboard bench for lib_mul_rsp_serializer. Two instances
//               share one stimulus stream: u_lo (LO_FIRST=1, CNT_W=16) and
//               u_hi (LO_FIRST=0, CNT_W=4). Accepted products are queued as
//               expected beats; a monitor pops and compares on output fire.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lib_mul_rsp_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] cnt_lo;
  logic [3:0]  cnt_hi;

  lib_mul_rsp_serializer_if if_lo ();
  lib_mul_rsp_serializer_if if_hi ();

  lib_mul_rsp_serializer #(.LO_FIRST(1'b1), .CNT_W(16)) u_lo (
    .clk      (clk),
    .reset    (reset),
    .bus      (if_lo),
    .prod_cnt (cnt_lo)
  );

  lib_mul_rsp_serializer #(.LO_FIRST(1'b0), .CNT_W(4)) u_hi (
    .clk      (clk),
    .reset    (reset),
    .bus      (if_hi),
    .prod_cnt (cnt_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    bit          second;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_cnt = 0;   // products fully emitted since last reset

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [63:0] d, input logic r);
    if_lo.rsp_val = v;  if_hi.rsp_val = v;
    if_lo.rsp_in  = d;  if_hi.rsp_in  = d;
    if_lo.out_rdy = r;  if_hi.out_rdy = r;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n, input bit rand_rdy, input logic r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_in(1'b0, rnd64(), rand_rdy ? logic'(($urandom % 4) != 0) : r);
    end
  endtask

  // Holds the product valid until it is accepted (bounded).
  task automatic send(input logic [63:0] p, input bit rand_rdy, input logic r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      set_in(1'b1, p, rand_rdy ? logic'(($urandom % 4) != 0) : r);
      #2;
      if (if_lo.rsp_rdy === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept for %h", p);
    end
  endtask

  // Tracker: every accepted product becomes two expected beats.
  always begin : p_track
    @(negedge clk);
    #4;
    if (!reset && if_lo.rsp_val && if_lo.rsp_rdy === 1'b1) begin
      exp_q.push_back('{p: if_lo.rsp_in, second: 1'b0});
      exp_q.push_back('{p: if_lo.rsp_in, second: 1'b1});
    end
  end

  // Monitor: compares handshake, data and count against the model each cycle.
  always begin : p_mon
    int          pend;
    logic        exp_rdy;
    beat_t       e;
    logic [31:0] w_lo_exp;
    logic [31:0] w_hi_exp;
    logic [31:0] c;
    @(negedge clk);
    #3;
    if (reset) begin
      check("rst_rsp_rdy",  {63'd0, if_lo.rsp_rdy},  64'd0);
      check("rst_out_val",  {63'd0, if_lo.out_val},  64'd0);
      check("rst_out_last", {63'd0, if_lo.out_last}, 64'd0);
      check("rst_out_val_hi", {63'd0, if_hi.out_val}, 64'd0);
      exp_q.delete();
      done_cnt = 0;
    end else begin
      pend    = exp_q.size();
      exp_rdy = (pend == 0) || (pend == 1 && if_lo.out_rdy);
      c       = done_cnt;
      check("rsp_rdy",    {63'd0, if_lo.rsp_rdy}, {63'd0, exp_rdy});
      check("rsp_rdy_hi", {63'd0, if_hi.rsp_rdy}, {63'd0, exp_rdy});
      check("out_val",    {63'd0, if_lo.out_val}, {63'd0, pend != 0});
      check("out_val_hi", {63'd0, if_hi.out_val}, {63'd0, pend != 0});
      check("prod_cnt",    {48'd0, cnt_lo}, {48'd0, c[15:0]});
      check("prod_cnt_hi", {60'd0, cnt_hi}, {60'd0, c[3:0]});
      if (pend != 0) begin
        e = exp_q[0];
        w_lo_exp = e.second ? e.p[63:32] : e.p[31:0];
        w_hi_exp = e.second ? e.p[31:0]  : e.p[63:32];
        check("out_data",    {32'd0, if_lo.out_data}, {32'd0, w_lo_exp});
        check("out_data_hi", {32'd0, if_hi.out_data}, {32'd0, w_hi_exp});
        check("out_last",    {63'd0, if_lo.out_last}, {63'd0, e.second});
        check("out_last_hi", {63'd0, if_hi.out_last}, {63'd0, e.second});
        if (if_lo.out_rdy) begin
          void'(exp_q.pop_front());
          if (e.second) done_cnt++;
        end
      end else begin
        check("idle_data",    {32'd0, if_lo.out_data}, 64'd0);
        check("idle_data_hi", {32'd0, if_hi.out_data}, 64'd0);
        check("idle_last",    {63'd0, if_lo.out_last}, 64'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_in(1'b0, 64'd0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, rnd64(), 1'b1);

    // Single product, consumer always ready
    send(64'hFFFFFFFE_00000001, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);

    // Back-to-back products with no bubble
    send(64'h00000000_00000018, 1'b0, 1'b1);
    send(64'hFFFFFFFF_FFFFFFC0, 1'b0, 1'b1);
    idle(4, 1'b0, 1'b1);

    // Consumer stall of three cycles during the first beat
    send(64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b1);

    // Randomized traffic with random consumer back-pressure
    for (int k = 0; k < 150; k++) begin
      if (($urandom % 3) != 0) send(rnd64(), 1'b1, 1'b1);
      else idle(1 + ($urandom % 3), 1'b1, 1'b1);
    end
    idle(8, 1'b0, 1'b1);

    // Reset while the second beat is on the bus
    send(64'h12345678_9ABCDEF0, 1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b0, rnd64(), 1'b1);
    @(negedge clk);
    #1;
    check("pre_rst_last", {63'd0, if_lo.out_last}, 64'd1);
    reset = 1'b1;
    set_in(1'b0, rnd64(), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, rnd64(), 1'b1);
    #1;
    check("post_rst_val", {63'd0, if_lo.out_val}, 64'd0);
    check("post_rst_cnt", {48'd0, cnt_lo}, 64'd0);

    // 17 products streamed; the 4-bit counter wraps to 1
    for (int k = 0; k < 17; k++) begin
      send((k == 0) ? 64'h00DEADBE_E0000000 : rnd64(), 1'b0, 1'b1);
    end
    idle(5, 1'b0, 1'b1);
    #1;
    check("final_cnt",    {48'd0, cnt_lo}, 64'd17);
    check("final_cnt_hi", {60'd0, cnt_hi}, 64'd1);
    check("final_drain",  64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lib_mul_rsp_serializer.md
LIB_MUL_RSP_SERIALIZER -- requirements
Module: lib_mul_rsp_serializer

Interface
REQ-001 Parameter LO_FIRST, default 1: 1 = low word emitted first, 0 = high word first.
REQ-002 Parameter CNT_W, default 16: width of the completed-product counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rsp_in  input  64  product from the multiplier's rsp_out; {hi[63:32], lo[31:0]}.
REQ-006 rsp_val  input  1  product valid.
REQ-007 rsp_rdy  output  1  serializer can accept a product.
REQ-008 out_data  output  32  current result word.
REQ-009 out_val  output  1  out_data valid.
REQ-010 out_rdy  input  1  consumer accepts out_data.
REQ-011 out_last  output  1  high on the second word of a product.
REQ-012 prod_cnt  output  CNT_W  count of fully emitted products.

Function
REQ-013 The block SHALL split each 64-bit product into two 32-bit val/rdy beats in LO_FIRST order.
REQ-014 Input fire SHALL be rsp_val && rsp_rdy; output fire SHALL be out_val && out_rdy.
REQ-015 FSM states SHALL be IDLE, FIRST and SECOND; out_val SHALL equal (state != IDLE).
REQ-016 IDLE + input fire: capture rsp_in into the 64-bit holding register; go to FIRST.
REQ-017 FIRST + output fire: go to SECOND; FIRST without output fire: hold.
REQ-018 SECOND + output fire + input fire: capture the new product; go to FIRST (no bubble).
REQ-019 SECOND + output fire, no input fire: go to IDLE; SECOND without output fire: hold.
REQ-020 rsp_rdy SHALL be combinational: !reset && (state==IDLE || (state==SECOND && out_rdy)).
REQ-021 The holding register SHALL load only on input fire; rsp_in values (including X/Z) at any other time SHALL have no effect.
REQ-022 out_data in FIRST SHALL be lo when LO_FIRST=1 and hi when LO_FIRST=0; in SECOND, the other half.
REQ-023 out_last SHALL be 1 only in SECOND.
REQ-024 out_data and out_last SHALL be stable while out_val=1 and out_rdy=0.
REQ-025 Latency: a product accepted in cycle N SHALL present its first beat in cycle N+1.
REQ-026 Sustained throughput SHALL be one word per cycle when rsp_val and out_rdy are held high.
REQ-027 prod_cnt SHALL increment by 1 on each output fire in SECOND and wrap from all-ones to 0.
REQ-028 out_data SHALL read 0 in IDLE.

Reset
REQ-029 While reset=1: state SHALL be IDLE and out_val, out_last and rsp_rdy SHALL be 0.
REQ-030 Reset SHALL clear prod_cnt and the holding register to 0.
REQ-031 Reset asserted mid-product SHALL discard the product with no further beats; after release, rsp_rdy=1 in the next cycle.

Structure
REQ-032 Package lib_mul_pkg SHALL hold the FSM state enum, product width (64) and word width (32) constants.
REQ-033 The block SHALL be one flat module with no sub-module; the FSM, register and counter are too small to split.

Verification
REQ-034 Product 0xFFFFFFFE_00000001, LO_FIRST=1, out_rdy=1 -> beat 0x00000001 (last=0), then 0xFFFFFFFE (last=1), prod_cnt=1.
REQ-035 Products 0x00000000_00000018 and 0xFFFFFFFF_FFFFFFC0 back-to-back, out_rdy=1 -> four consecutive beats 0x18, 0x0, 0xFFFFFFC0, 0xFFFFFFFF; no idle cycle; rsp_rdy=1 on the second beat.
REQ-036 out_rdy=0 for 3 cycles during FIRST -> out_data held constant and rsp_rdy=0; beats resume unchanged when out_rdy=1.
REQ-037 LO_FIRST=0, product 0x00DEADBE_E0000000 -> beats 0x00DEADBE, then 0xE0000000 with last=1.
REQ-038 Reset pulsed while in SECOND -> out_val=0 in the next cycle, prod_cnt=0, and the next product is emitted cleanly.
REQ-039 CNT_W=4, 17 products -> prod_cnt reads 1 after wrap.
